decode_queue_stage: RTL

- Parametrised successor to the single-entry decode pipeline register. Sits between fetch and execute.
- Replaces the one D-latch with a DEPTH-entry in-order instruction queue. Fetch keeps streaming while execute stalls.
- Load-use hazard check is generalised to a configurable number of downstream load stages.
- Adds flush-on-mispredict and a stall performance counter. Register-file read and forwarding stay outside, driven from the D_* head outputs.

---
 rtl/decode_queue_stage_pkg.sv | 39 +++
 rtl/decode_queue_stage_load_use_check.sv | 24 ++
 rtl/decode_queue_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/decode_queue_stage_pkg.sv
// Shared decode-queue definitions: commit window defaults and the
// fetch bundle field layout used by fetch (pack) and execute (unpack).
package decode_queue_stage_pkg;

  localparam logic [31:0] COMMIT_LO_DEF = 32'h8000_0000;
  localparam logic [31:0] COMMIT_HI_DEF = 32'h87ff_ffff;

  localparam int B_OPC_LSB  = 0;
  localparam int B_OPC_W    = 7;
  localparam int B_F3_LSB   = 7;
  localparam int B_F3_W     = 3;
  localparam int B_F7_LSB   = 10;
  localparam int B_F7_W     = 7;
  localparam int B_RD_LSB   = 17;
  localparam int B_RD_W     = 5;
  localparam int B_IMM_LSB  = 22;
  localparam int B_IMM_W    = 32;
  localparam int B_PRED_LSB = 54;
  localparam int B_PRED_W   = 2;
  localparam int B_USED_W   = 56;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic        commit;
  } hdr_t;

  function automatic logic in_range(
    input logic [31:0] pc,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/decode_queue_stage_load_use_check.sv
// Load-use hazard detect against one downstream stage.
// x0 and unread sources never match.
module load_use_check
  import decode_queue_stage_pkg::*;
(
  input  logic       valid,
  input  logic       is_load,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use1,
  input  logic       use2,
  output logic       hit
);

  logic m1;
  logic m2;

  assign m1  = use1 && (rd == rs1);
  assign m2  = use2 && (rd == rs2);
  assign hit = valid && is_load &&
               (rd != 5'd0) && (m1 || m2);

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: in-order instruction queue between fetch and execute
// with load-use stall, mispredict flush and stall counter.
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int          PAYLOAD_W = 128,
  parameter int          DEPTH     = 4,
  parameter int          PTR_W     = 2,
  parameter int          HAZ_M     = 1,
  parameter logic [31:0] COMMIT_LO = COMMIT_LO_DEF,
  parameter logic [31:0] COMMIT_HI = COMMIT_HI_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_to_d_valid,
  output logic                 d_allow_in,
  input  logic [31:0]          f_pc,
  input  logic [4:0]           f_rs1,
  input  logic [4:0]           f_rs2,
  input  logic                 f_use1,
  input  logic                 f_use2,
  input  logic [PAYLOAD_W-1:0] f_bundle,
  input  logic                 e_allow_in,
  output logic                 d_to_e_valid,
  input  logic                 flush,
  input  logic                 e_valid,
  input  logic                 e_is_load,
  input  logic [4:0]           E_rd,
  input  logic                 m_valid,
  input  logic                 m_is_load,
  input  logic [4:0]           M_rd,
  output logic [31:0]          D_pc,
  output logic [4:0]           D_rs1,
  output logic [4:0]           D_rs2,
  output logic [PAYLOAD_W-1:0] D_bundle,
  output logic                 D_commit,
  output logic [PTR_W:0]       d_count,
  output logic [31:0]          d_stall_cnt
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  hdr_t                 hdr_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W:0]       count;
  logic [31:0]          stall_cnt;
  hdr_t                 head;
  logic                 nonempty;
  logic                 e_hit;
  logic                 m_hit;
  logic                 hazard;
  logic                 push;
  logic                 pop;

  // Head is forced to zero while empty so stale entries never leak.
  assign nonempty = (count != '0);
  assign head     = nonempty ? hdr_q[rd_ptr] : '0;
  assign D_bundle = nonempty ? pay_q[rd_ptr] : '0;
  assign D_pc     = head.pc;
  assign D_rs1    = head.rs1;
  assign D_rs2    = head.rs2;
  assign D_commit = head.commit;

  load_use_check u_e (
    .valid   (e_valid),
    .is_load (e_is_load),
    .rd      (E_rd),
    .rs1     (head.rs1),
    .rs2     (head.rs2),
    .use1    (head.use1),
    .use2    (head.use2),
    .hit     (e_hit)
  );

  if (HAZ_M != 0) begin : g_m
    load_use_check u_m (
      .valid   (m_valid),
      .is_load (m_is_load),
      .rd      (M_rd),
      .rs1     (head.rs1),
      .rs2     (head.rs2),
      .use1    (head.use1),
      .use2    (head.use2),
      .hit     (m_hit)
    );
  end else begin : g_no_m
    assign m_hit = 1'b0;
  end

  assign hazard       = e_hit || m_hit;
  assign d_allow_in   = (count != FULL);
  assign push         = f_to_d_valid && d_allow_in && !flush;
  assign d_to_e_valid = nonempty && !hazard && !flush;
  assign pop          = d_to_e_valid && e_allow_in;
  assign d_count      = count;
  assign d_stall_cnt  = stall_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      hdr_q[wr_ptr] <= '{
        pc:     f_pc,
        rs1:    f_rs1,
        rs2:    f_rs2,
        use1:   f_use1,
        use2:   f_use2,
        commit: in_range(f_pc, COMMIT_LO, COMMIT_HI)
      };
      pay_q[wr_ptr] <= f_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (nonempty && hazard && !flush &&
                 (stall_cnt != 32'hffff_ffff)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
